// File: rtl/mult_div_ctrl.sv
// Issue/commit controller for the EX-stage multiply/divide unit.
// Owns HI/LO, stalls EX while an operation is in flight, handles flush and watchdog.
module mult_div_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [5:0]  ex_funct,
    input  logic [31:0] ex_operand_1,
    input  logic [31:0] ex_operand_2,
    input  logic        flush,
    output logic        stall_req,
    output logic [31:0] hilo_rdata,
    output logic [5:0]  md_funct,
    output logic [31:0] md_operand_1,
    output logic [31:0] md_operand_2,
    output logic        md_flush,
    input  logic        md_done,
    input  logic [63:0] md_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        timeout
);

    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MTLO = 6'h13;
    localparam int         CW     = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] wd_cnt;
    logic          is_md;
    logic          launch;

    assign is_md     = (ex_funct[5:2] == 4'b0110);
    assign launch    = (state == IDLE) && ex_valid && is_md && !flush;
    assign stall_req = launch || (state == BUSY);

    always_comb begin
        hilo_rdata = 32'h0;
        case (ex_funct)
            F_MFHI:  hilo_rdata = hi;
            F_MFLO:  hilo_rdata = lo;
            default: hilo_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wd_cnt       <= '0;
            hi           <= 32'h0;
            lo           <= 32'h0;
            md_funct     <= 6'h0;
            md_operand_1 <= 32'h0;
            md_operand_2 <= 32'h0;
            md_flush     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            md_flush <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        md_flush <= 1'b1;
                        md_funct <= 6'h0;
                    end else if (ex_valid) begin
                        if (is_md) begin
                            md_funct     <= ex_funct;
                            md_operand_1 <= ex_operand_1;
                            md_operand_2 <= ex_operand_2;
                            wd_cnt       <= '0;
                            state        <= BUSY;
                        end else if (ex_funct == F_MTHI) begin
                            hi <= ex_operand_1;
                        end else if (ex_funct == F_MTLO) begin
                            lo <= ex_operand_1;
                        end
                    end
                end
                BUSY: begin
                    // wd_cnt == 0 marks the first BUSY cycle, where md_done may be stale
                    if (flush) begin
                        state    <= IDLE;
                        md_flush <= 1'b1;
                        md_funct <= 6'h0;
                    end else if (md_done && (wd_cnt != '0)) begin
                        {hi, lo} <= md_result;
                        md_funct <= 6'h0;
                        state    <= DONE;
                    end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                        state    <= IDLE;
                        timeout  <= 1'b1;
                        md_flush <= 1'b1;
                        md_funct <= 6'h0;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
